// File: rtl/ahb_lite_bus_ctrl_pkg.sv
// Shared definitions for the AHB-Lite bus controller slice: transfer types,
// data-phase select encoding, default-slave states and response bundle.
package ahb_lite_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [1:0] {
        DSEL_NONE = 2'd0,
        DSEL_S0   = 2'd1,
        DSEL_S1   = 2'd2,
        DSEL_DEF  = 2'd3
    } Dsel_t;

    typedef enum logic [1:0] {
        DS_OKAY = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } DsState_t;

    // Response/ready pair returned to the master (data travels separately).
    typedef struct packed {
        logic hresp;
        logic hready;
    } Slave_t;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == NONSEQ) || (htrans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: produces the two-cycle AHB ERROR response
// (ERR1: wait + ERROR, ERR2: ready + ERROR) for unmapped transfers and for
// forced errors such as a wait-state timeout.
module ahb_default_slave
    import ahb_lite_bus_ctrl_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic start,
    input  logic force_err,
    output logic ds_hready,
    output logic ds_hresp
);

    DsState_t state_q, state_d;

    // Next-state: ERR1 always advances; ERR2 can chain straight into a new ERR1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_OKAY: if (start || force_err) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = start ? DS_ERR1 : DS_OKAY;
            default: state_d = DS_OKAY;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= DS_OKAY;
        end else begin
            state_q <= state_d;
        end
    end

    assign ds_hready = (state_q != DS_ERR1);
    assign ds_hresp  = (state_q != DS_OKAY);

endmodule

// File: rtl/ahb_lite_bus_ctrl.sv
// AHB-Lite interconnect controller: address decode to two slaves plus a
// built-in default slave, registered data-phase select and response mux.
// Optional wait-state timeout enabled by defining HREADY_TIMEOUT_EN.
module ahb_lite_bus_ctrl
    import ahb_lite_bus_ctrl_pkg::*;
#(
    parameter int unsigned           ADDRWIDTH = 32,
    parameter int unsigned           DATAWIDTH = 32,
    parameter logic [ADDRWIDTH-1:0]  S0_BASE   = 32'h0000_0000,
    parameter logic [ADDRWIDTH-1:0]  S0_MASK   = 32'hF000_0000,
    parameter logic [ADDRWIDTH-1:0]  S1_BASE   = 32'h1000_0000,
    parameter logic [ADDRWIDTH-1:0]  S1_MASK   = 32'hF000_0000
`ifdef HREADY_TIMEOUT_EN
    ,
    parameter int unsigned           TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HSEL0,
    output logic                 HSEL1,
    input  logic [DATAWIDTH-1:0] HRDATA0,
    input  logic                 HRESP0,
    input  logic                 HREADYOUT0,
    input  logic [DATAWIDTH-1:0] HRDATA1,
    input  logic                 HRESP1,
    input  logic                 HREADYOUT1,
    output logic [DATAWIDTH-1:0] HRDATA,
    output logic                 HRESP,
    output logic                 HREADY,
    output logic [1:0]           MUX_SEL,
    output logic                 TIMEOUT
);

    logic   s0_match, s1_match;
    logic   unmapped_active;
    logic   start, force_err;
    logic   ds_hready, ds_hresp;
    Dsel_t  dsel_q, dsel_d;
    Slave_t rsp;
    logic [DATAWIDTH-1:0] rdata;

    // Address decode; slave 0 wins where the two windows overlap.
    always_comb begin
        s0_match        = ((HADDR & S0_MASK) == S0_BASE);
        s1_match        = ((HADDR & S1_MASK) == S1_BASE) && !s0_match;
        unmapped_active = !s0_match && !s1_match && trans_active(HTRANS);
        if (s0_match) begin
            dsel_d = DSEL_S0;
        end else if (s1_match) begin
            dsel_d = DSEL_S1;
        end else if (unmapped_active) begin
            dsel_d = DSEL_DEF;
        end else begin
            dsel_d = DSEL_NONE;
        end
    end

    assign HSEL0 = s0_match;
    assign HSEL1 = s1_match;
    assign start = HREADY && unmapped_active;

    // Data-phase select advances only when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= DSEL_NONE;
        end else if (HREADY) begin
            dsel_q <= dsel_d;
        end
    end

    assign MUX_SEL = dsel_q;

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .force_err (force_err),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp)
    );

    // Response mux back to the master.
    always_comb begin
        rdata = '0;
        rsp   = '{hresp: 1'b0, hready: 1'b1};
        case (dsel_q)
            DSEL_S0: begin
                rdata = HRDATA0;
                rsp   = '{hresp: HRESP0, hready: HREADYOUT0};
            end
            DSEL_S1: begin
                rdata = HRDATA1;
                rsp   = '{hresp: HRESP1, hready: HREADYOUT1};
            end
            DSEL_DEF: rsp = '{hresp: ds_hresp, hready: ds_hready};
            default: ;
        endcase
`ifdef HREADY_TIMEOUT_EN
        // A timeout error sequence replaces whatever the stalled slave drives.
        if (ds_hresp) begin
            rdata = '0;
            rsp   = '{hresp: ds_hresp, hready: ds_hready};
        end
`endif
    end

    assign HRDATA = rdata;
    assign HRESP  = rsp.hresp;
    assign HREADY = rsp.hready;

`ifdef HREADY_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            waiting;
    logic            timeout_q;

    // Count wait cycles of the selected slave; fire on the last allowed one.
    always_comb begin
        waiting   = !ds_hresp &&
                    (((dsel_q == DSEL_S0) && !HREADYOUT0) ||
                     ((dsel_q == DSEL_S1) && !HREADYOUT1));
        force_err = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        cnt_d     = (waiting && !force_err) ? cnt_q + CntW'(1) : '0;
    end

    // Counter and the TIMEOUT pulse, which lines up with the ERR1 cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= force_err;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign force_err = 1'b0;
    assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: doc/ahb_lite_bus_ctrl.md
Name: ahb_lite_bus_ctrl

Overview:
AHB-Lite interconnect controller sitting between the single bus master and the two slaves.
- Decodes HADDR into HSEL0, HSEL1 or a built-in default slave.
- Registers the data-phase selection that drives MUX_SEL.
- Muxes slave responses back to the master.
- Generates the two-cycle ERROR response for unmapped transfers.

Parameters:
ADDRWIDTH, 32, address width
DATAWIDTH, 32, read-data width
S0_BASE, 32'h0000_0000, slave 0 base; match when (HADDR & S0_MASK) == S0_BASE
S0_MASK, 32'hF000_0000, slave 0 decode mask
S1_BASE, 32'h1000_0000, slave 1 base
S1_MASK, 32'hF000_0000, slave 1 decode mask
TIMEOUT_CYCLES, 16, wait-state limit (optional feature only)

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESET  in  1  synchronous reset, active-high
HADDR  in  ADDRWIDTH  master address-phase address
HTRANS  in  2  master transfer type (Trans_t)
HSEL0  out  1  slave 0 select (combinational decode)
HSEL1  out  1  slave 1 select (combinational decode)
HRDATA0/HRESP0/HREADYOUT0  in  DATAWIDTH/1/1  slave 0 response
HRDATA1/HRESP1/HREADYOUT1  in  DATAWIDTH/1/1  slave 1 response
HRDATA  out  DATAWIDTH  muxed read data to master
HRESP  out  1  muxed response (0 OKAY, 1 ERROR)
HREADY  out  1  muxed ready to master and all slaves
MUX_SEL  out  2  registered data-phase select (Dsel_t)
TIMEOUT  out  1  one-cycle pulse on wait-state timeout

Behaviour:
Address decode (combinational, every cycle):
- HSEL0 = S0 match.
- HSEL1 = S1 match and not S0 match; slave 0 wins on overlap.
- A default-slave hit is neither match.

Data-phase select register dsel (MUX_SEL):
- Loaded only on edges where HREADY=1.
- Next value: DSEL_S0 or DSEL_S1 per decode; DSEL_DEF if unmapped and HTRANS in {NONSEQ, SEQ}; DSEL_NONE otherwise (unmapped IDLE/BUSY).
- Holds while HREADY=0.

Response mux:
- DSEL_S0 / DSEL_S1: pass {HRDATA, HRESP, HREADYOUT} of that slave.
- DSEL_NONE: HRDATA=0, HRESP=0, HREADY=1.
- DSEL_DEF: HRDATA=0; HRESP and HREADY from the default-slave FSM.

Default-slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
- DS_OKAY -> DS_ERR1 on an HREADY=1 edge with an unmapped NONSEQ/SEQ address phase.
- DS_ERR1: HREADY=0, HRESP=1; always -> DS_ERR2 next cycle.
- DS_ERR2: HREADY=1, HRESP=1. Next: DS_ERR1 if another unmapped NONSEQ/SEQ transfer is accepted this edge, else DS_OKAY.
- A master change of HTRANS to IDLE during DS_ERR1 is legal; the sequence still completes.

Latency:
- Zero-wait slaves give single-cycle data phases.
- Unmapped transfer: exactly 2 data-phase cycles.

Reset, on any HCLK edge with HRESET=1, including mid-ERROR sequence:
- dsel=DSEL_NONE, FSM=DS_OKAY, timeout counter=0.
- Outputs after reset: HREADY=1, HRESP=0, HRDATA=0, MUX_SEL=DSEL_NONE, TIMEOUT=0.
- HSEL0/HSEL1 follow decode.

Optional Feature:
HREADY_TIMEOUT_EN
- With macro:
  - Counter increments each cycle dsel in {S0, S1} and the selected HREADYOUT=0.
  - Clears when HREADYOUT=1 or dsel changes.
  - On reaching TIMEOUT_CYCLES, the controller overrides the slave response with the ERR1/ERR2 sequence (FSM reused) and pulses TIMEOUT=1 in the ERR1 cycle.
  - dsel is then reloaded on the ERR2 edge.
- Without macro: no counter logic; TIMEOUT tied 0; waits are unbounded.

Decomposition:
Shared package Definitions gains:
- Dsel_t enum logic[1:0] {DSEL_NONE=0, DSEL_S0=1, DSEL_S1=2, DSEL_DEF=3}.
- DsState_t enum {DS_OKAY, DS_ERR1, DS_ERR2}.
- Existing Trans_t and Slave_t used for HTRANS and response bundles.

One sub-module, ahb_default_slave: owns the DS FSM. Inputs: HCLK, HRESET, start, force_err. Outputs: ds_hready, ds_hresp. The controller owns decode, dsel, mux and timeout counter.

Test Plan:
- Reset: HRESET=1 for 2 cycles mid-transfer -> HREADY=1, HRESP=0, HRDATA=0, MUX_SEL=0 on first post-reset cycle.
- Decode: NONSEQ HADDR=32'h0000_0040, then 32'h1000_0080, zero-wait slaves -> HSEL0=1 then HSEL1=1. MUX_SEL=1 then 2 one cycle later. HRDATA equals HRDATA0, then HRDATA1.
- Unmapped: NONSEQ HADDR=32'h2000_0000 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then OKAY. Back-to-back unmapped NONSEQ accepted in ERR2 -> ERR1 again immediately.
- Unmapped IDLE: HTRANS=IDLE, HADDR=32'h3000_0000 -> MUX_SEL=0, HREADY=1, HRESP=0, no ERROR.
- Wait states: slave 1 holds HREADYOUT1=0 for 3 cycles -> HREADY=0 for 3 cycles, MUX_SEL held at 2, and the address presented during the waits is not latched.
- Timeout (macro on, TIMEOUT_CYCLES=16): slave 0 stuck HREADYOUT0=0 -> after 16 wait cycles TIMEOUT=1 for one cycle, then the ERR1/ERR2 response.
